// File: rtl/serial_adder_ctrl.sv
// Button-driven operand loader and bit-serial 8-bit adder feeding a display value.
// Latency: press-to-pulse 2 sync + DB_CYCLES cycles; load 1 cycle after pulse; add 8 busy cycles, done on the 9th.
// Backpressure: none; button pulses that arrive while an add is running are dropped.
//
// Ports:
//   clk, clr             : clock and asynchronous active-high reset
//   sw[7:0]              : operand switches, sampled only when a load pulse is taken
//   btn_a, btn_b, btn_go : raw push buttons (load A, load B, start A+B)
//   x[7:0]               : displayed value; changes only on a load or add completion
//   cout                 : carry out of the last completed add
//   busy                 : high while the serial add runs
//   done                 : one-cycle pulse when a sum is written to x
module serial_adder_ctrl #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] sw,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_go,
  output logic [7:0] x,
  output logic       cout,
  output logic       busy,
  output logic       done
);

  localparam int CW = 20;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic {IDLE, ADD} state_t;

  // Debouncers, bit 0 = a, bit 1 = b, bit 2 = go.
  logic [2:0]         btn_raw;
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;
  logic [2:0]         db_q, db_d;
  logic [2:0]         db_dly_q, db_dly_d;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         press;
  logic               p_a, p_b, p_go;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] sa_q, sa_d;
  logic [7:0] sb_q, sb_d;
  logic [7:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] x_q, x_d;
  logic       cout_q, cout_d;
  logic       done_q, done_d;
  logic       sum_bit, carry;

  assign btn_raw = {btn_go, btn_b, btn_a};

  // Debounce: a level change is accepted only after DB_CYCLES consecutive
  // samples disagree with the current level; any agreeing sample restarts it.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    cnt_d    = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases produce nothing.
  assign press = db_q & ~db_dly_q;
  assign p_a   = press[0];
  assign p_b   = press[1];
  assign p_go  = press[2];

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      bitcnt_q <= '0;
      x_q      <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      bitcnt_q <= bitcnt_d;
      x_q      <= x_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (p_go) state_d = ADD;
      ADD:     if (bitcnt_q == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and outputs
  assign sum_bit = sa_q[0] ^ sb_q[0] ^ c_q;
  assign carry   = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    c_d      = c_q;
    bitcnt_d = bitcnt_q;
    x_d      = x_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    busy     = (state_q == ADD);
    case (state_q)
      IDLE: begin
        // go wins over a, a over b; losers in the same cycle are dropped.
        if (p_go) begin
          sa_d     = a_q;
          sb_d     = b_q;
          c_d      = 1'b0;
          bitcnt_d = '0;
        end else if (p_a) begin
          a_d = sw;
          x_d = sw;
        end else if (p_b) begin
          b_d = sw;
          x_d = sw;
        end
      end
      ADD: begin
        c_d      = carry;
        sa_d     = {1'b0, sa_q[7:1]};
        sb_d     = {1'b0, sb_q[7:1]};
        acc_d    = {sum_bit, acc_q[7:1]};
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          x_d    = {sum_bit, acc_q[7:1]};
          cout_d = carry;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign x    = x_q;
  assign cout = cout_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] sw = '0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       btn_go = 1'b0;
  logic [7:0] x;
  logic       cout, busy, done;

  serial_adder_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .sw(sw), .btn_a(btn_a), .btn_b(btn_b), .btn_go(btn_go),
    .x(x), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_add;
    logic [7:0] x;
    logic       cout;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] mdl_x = '0;
  logic       mdl_cout = 1'b0;
  logic [7:0] prev_x;
  int         busy_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected load event; loads that leave x unchanged are not observable.
  task automatic exp_load(input logic [7:0] v);
    if (v !== mdl_x) sb_q.push_back('{is_add: 1'b0, x: v, cout: mdl_cout});
    mdl_x = v;
  endtask

  task automatic exp_add(input logic [7:0] v, input logic c);
    sb_q.push_back('{is_add: 1'b1, x: v, cout: c});
    mdl_x    = v;
    mdl_cout = c;
  endtask

  // m = {go, b, a}; hold long enough to debounce, then release and settle.
  task automatic press(input logic [2:0] m, input logic [7:0] v);
    @(negedge clk);
    sw = v;
    {btn_go, btn_b, btn_a} = m;
    repeat (10) @(negedge clk);
    {btn_go, btn_b, btn_a} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  // Monitor: any done pulse or change on x is an event to match in order.
  always @(negedge clk) begin
    if (clr) begin
      prev_x   = x;
      busy_len = 0;
    end else begin
      if (done || x !== prev_x) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event x=%0h done=%0b cout=%0b expected no event", x, done, cout);
        end else begin
          e = sb_q.pop_front();
          chk("event_kind_done", 32'(done), 32'(e.is_add));
          chk("event_x", 32'(x), 32'(e.x));
          chk("event_cout", 32'(cout), 32'(e.cout));
          if (e.is_add) begin
            chk("busy_len", 32'(busy_len), 32'd8);
            chk("busy_low_at_done", 32'(busy), 32'd0);
          end
        end
        if (done) busy_len = 0;
      end
      if (busy) busy_len++;
      prev_x = x;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_x", 32'(x), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    clr = 1'b0;
    repeat (3) @(negedge clk);

    // Load and add
    exp_load(8'h5A); press(3'b001, 8'h5A);
    exp_load(8'h3C); press(3'b010, 8'h3C);
    exp_add(8'h96, 1'b0); press(3'b100, 8'h00);

    // Carry and wrap; cout holds through a later load
    exp_load(8'hFF); press(3'b001, 8'hFF);
    exp_load(8'h01); press(3'b010, 8'h01);
    exp_add(8'h00, 1'b1); press(3'b100, 8'h00);
    exp_load(8'h10); press(3'b001, 8'h10);

    // Bounce rejection: 3-cycle highs never reach 4 stable samples
    @(negedge clk);
    sw = 8'h77;
    for (int i = 0; i < 7; i++) begin
      btn_a = 1'b1; repeat (3) @(negedge clk);
      btn_a = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_x_unchanged", 32'(x), 32'h10);
    exp_load(8'h77); press(3'b001, 8'h77);

    // Busy lockout: a-press lands mid-add, second go pulse lands in the last busy cycle
    exp_load(8'h80); press(3'b001, 8'h80);
    exp_load(8'h80); press(3'b010, 8'h80);
    exp_add(8'h00, 1'b1);
    @(negedge clk); btn_go = 1'b1;
    repeat (4) @(negedge clk); btn_go = 1'b0;
    repeat (2) @(negedge clk); btn_a = 1'b1; sw = 8'h11;
    repeat (2) @(negedge clk); btn_go = 1'b1;
    repeat (10) @(negedge clk); btn_go = 1'b0; btn_a = 1'b0;
    repeat (15) @(negedge clk);
    exp_load(8'h01); press(3'b010, 8'h01);
    exp_add(8'h81, 1'b0); press(3'b100, 8'h00);

    // Simultaneous: go beats a, a beats b
    exp_add(8'h81, 1'b0); press(3'b101, 8'h22);
    exp_load(8'h33); press(3'b011, 8'h33);
    exp_add(8'h34, 1'b0); press(3'b100, 8'h00);

    // Reset in cycle 4 of an add
    @(negedge clk); btn_go = 1'b1;
    n = 0;
    while (!busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("busy_seen_before_reset", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    btn_go = 1'b0;
    repeat (2) @(negedge clk);
    chk("midadd_reset_x", 32'(x), 32'd0);
    chk("midadd_reset_cout", 32'(cout), 32'd0);
    chk("midadd_reset_busy", 32'(busy), 32'd0);
    mdl_x = 8'h00;
    mdl_cout = 1'b0;
    clr = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    exp_load(8'h9C); press(3'b001, 8'h9C);
    exp_load(8'h64); press(3'b010, 8'h64);
    exp_add(8'h00, 1'b1); press(3'b100, 8'h00);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
